// File: rtl/mem_wb_stage.sv
// Memory + write-back back end: MEM register, data memory, and WB register that
// drive the register-file write port, plus a retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              REG_Write,
   input  logic              MEM_Write,
   input  logic              MEM_Read,
   input  logic              MEM_to_REG,
   input  logic              stall,
   output logic [DATA_W-1:0] write_back,
   output logic [REG_AW-1:0] wb_reg,
   output logic              wb_en,
   output logic [CNT_W-1:0]  retired
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic              mem_valid;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_store_data;
   logic [REG_AW-1:0] mem_dest_reg;
   logic              mem_REG_Write;
   logic              mem_MEM_Write;
   logic              mem_MEM_Read;
   logic              mem_MEM_to_REG;

   logic [DATA_W-1:0] mem_array [DEPTH];
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              store_commit;

   // Upper address bits are dropped, so addresses wrap within the array.
   assign mem_addr     = mem_alu_result[ADDR_W-1:0];
   assign mem_rdata    = mem_array[mem_addr];
   assign store_commit = mem_valid && mem_MEM_Write && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid      <= 1'b0;
         mem_alu_result <= '0;
         mem_store_data <= '0;
         mem_dest_reg   <= '0;
         mem_REG_Write  <= 1'b0;
         mem_MEM_Write  <= 1'b0;
         mem_MEM_Read   <= 1'b0;
         mem_MEM_to_REG <= 1'b0;
      end else if (!stall) begin
         mem_valid      <= in_valid;
         mem_alu_result <= alu_result;
         mem_store_data <= store_data;
         mem_dest_reg   <= dest_reg;
         mem_REG_Write  <= REG_Write;
         mem_MEM_Write  <= MEM_Write;
         mem_MEM_Read   <= MEM_Read;
         mem_MEM_to_REG <= MEM_to_REG;
      end
   end

   // A stalled store is held in MEM without writing, so it commits exactly once on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_array[i] <= '0;
         end
      end else if (store_commit) begin
         mem_array[mem_addr] <= mem_store_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_back <= '0;
         wb_reg     <= '0;
         wb_en      <= 1'b0;
         retired    <= '0;
      end else if (!stall) begin
         write_back <= mem_MEM_to_REG ? mem_rdata : mem_alu_result;
         wb_reg     <= mem_dest_reg;
         wb_en      <= mem_valid && mem_REG_Write;
         if (mem_valid) begin
            retired <= retired + 1'b1;
         end
      end else begin
         wb_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed write-back, forwarding, stall,
// reset and counter-wrap expectations.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] alu_result;
   logic [15:0] store_data;
   logic [2:0]  dest_reg;
   logic        REG_Write;
   logic        MEM_Write;
   logic        MEM_Read;
   logic        MEM_to_REG;
   logic        stall;
   logic [15:0] write_back;
   logic [2:0]  wb_reg;
   logic        wb_en;
   logic [15:0] retired;

   int checks = 0;
   int errors = 0;

   mem_wb_stage #(
      .DATA_W(16),
      .ADDR_W(8),
      .REG_AW(3),
      .CNT_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .alu_result(alu_result),
      .store_data(store_data),
      .dest_reg  (dest_reg),
      .REG_Write (REG_Write),
      .MEM_Write (MEM_Write),
      .MEM_Read  (MEM_Read),
      .MEM_to_REG(MEM_to_REG),
      .stall     (stall),
      .write_back(write_back),
      .wb_reg    (wb_reg),
      .wb_en     (wb_en),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [2:0] dr, input logic rw, input logic mw,
                        input logic mr, input logic m2r);
      in_valid   = v;
      alu_result = alu;
      store_data = sd;
      dest_reg   = dr;
      REG_Write  = rw;
      MEM_Write  = mw;
      MEM_Read   = mr;
      MEM_to_REG = m2r;
   endtask

   task automatic bubble();
      drive(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   logic wben_seen;

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      bubble();
      tick();
      tick();
      check("rst_wb_en", wb_en, 0);
      check("rst_write_back", write_back, 0);
      check("rst_retired", retired, 0);
      reset = 1'b0;

      // Traffic, then a reset (with stall) while a store sits in MEM.
      drive(1'b1, 16'h0005, 16'h1111, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0005, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      bubble();
      tick();
      check("pre_ldm_value", write_back, 16'h1111);
      check("pre_retired", retired, 2);
      drive(1'b1, 16'h0005, 16'h2222, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      stall = 1'b1;
      bubble();
      tick();
      tick();
      check("mid_rst_wb_en", wb_en, 0);
      check("mid_rst_write_back", write_back, 0);
      check("mid_rst_wb_reg", wb_reg, 0);
      check("mid_rst_retired", retired, 0);
      reset = 1'b0;
      stall = 1'b0;

      // ADD passthrough, with a latency check after the first edge.
      drive(1'b1, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("add_not_early", wb_en, 0);
      bubble();
      tick();
      check("add_value", write_back, 16'h1234);
      check("add_reg", wb_reg, 3);
      check("add_en", wb_en, 1);
      check("add_retired", retired, 1);

      // Memory was cleared and the in-flight store was discarded.
      drive(1'b1, 16'h0005, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      bubble();
      tick();
      check("ldm_after_rst", write_back, 16'h0000);
      check("ldm_after_rst_en", wb_en, 1);
      check("ldm_after_rst_ret", retired, 2);

      // STD 0x0105 then LDM 0x0005 back-to-back, followed by a stalled STD.
      drive(1'b1, 16'h0105, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0005, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("std_wb_en", wb_en, 0);
      check("std_retired", retired, 3);
      drive(1'b1, 16'h0010, 16'h00AA, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("fwd_value", write_back, 16'hBEEF);
      check("fwd_reg", wb_reg, 6);
      check("fwd_en", wb_en, 1);
      check("fwd_retired", retired, 4);

      stall = 1'b1;
      drive(1'b1, 16'h0010, 16'h00BB, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_wb_en", wb_en, 0);
      end
      check("stall_hold_value", write_back, 16'hBEEF);
      check("stall_hold_reg", wb_reg, 6);
      check("stall_retired", retired, 4);
      stall = 1'b0;
      drive(1'b1, 16'h0010, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("release_wb_en", wb_en, 0);
      check("release_retired", retired, 5);
      bubble();
      tick();
      check("stall_mem_value", write_back, 16'h00AA);
      check("stall_ldm_reg", wb_reg, 4);
      check("stall_ldm_en", wb_en, 1);
      check("stall_ldm_retired", retired, 6);

      // Zero result is written like any other value.
      drive(1'b1, 16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bubble();
      tick();
      check("zero_en", wb_en, 1);
      check("zero_value", write_back, 16'h0000);
      check("zero_reg", wb_reg, 2);

      // MEM_Read without MEM_to_REG writes back the ALU result.
      drive(1'b1, 16'h0010, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      bubble();
      tick();
      check("mr_no_m2r_value", write_back, 16'h0010);
      check("mr_no_m2r_en", wb_en, 1);
      check("mr_no_m2r_retired", retired, 8);

      // NOP opcode retires without writing; a bubble does not retire.
      drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      bubble();
      tick();
      check("nop_en", wb_en, 0);
      check("nop_retired", retired, 9);
      tick();
      check("bubble_retired", retired, 9);

      // Counter wrap: 65536 NOP retirements from zero.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b1, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      wben_seen = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         tick();
         if (wb_en !== 1'b0) wben_seen = 1'b1;
      end
      check("wrap_max", retired, 16'hFFFF);
      tick();
      if (wb_en !== 1'b0) wben_seen = 1'b1;
      check("wrap_zero", retired, 0);
      check("wrap_wb_en", wben_seen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory + write-back back end of the 5-opcode processor pipeline (LDM/STD/ADD/NOT/NOP).
- Consumes the decode control bundle (REG_Write, MEM_Write, MEM_Read, MEM_to_REG) and operands once they have passed through execute.
- Owns the data memory.
- Produces the write_back value, destination register index and write enable that drive the decode-stage register file write port.
- Two registered stages: MEM register, then WB register.

Parameters:
- DATA_W, 16, data word width (matches register file width).
- ADDR_W, 8, data memory address bits; depth = 2**ADDR_W words.
- REG_AW, 3, register index width (8 registers).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; the only clock and reset; all state on clk.
- in_valid  in  1  execute result valid this cycle.
- alu_result  in  DATA_W  ALU output; memory address for LDM/STD, result for ADD/NOT.
- store_data  in  DATA_W  read_data2 carried from decode; STD write data.
- dest_reg  in  REG_AW  destination register index.
- REG_Write, MEM_Write, MEM_Read, MEM_to_REG  in  1 each  decode control signals, carried through execute.
- stall  in  1  hold MEM register, insert bubble into WB.
- write_back  out  DATA_W  value to register file.
- wb_reg  out  REG_AW  register file write index.
- wb_en  out  1  register file write enable.
- retired  out  CNT_W  count of instructions leaving WB.

Behaviour:
- Reset (synchronous, has priority over everything):
  - MEM and WB registers cleared; mem_valid=0.
  - write_back=0, wb_reg=0, wb_en=0, retired=0.
  - All data memory words cleared to 0 at that edge.
  - Reset asserted mid-operation discards in-flight instructions, and any store in MEM does not commit.
- MEM register:
  - At each edge with stall=0, captures in_valid, alu_result, store_data, dest_reg and the four controls.
  - With stall=1, holds its contents.
- Memory address = mem_alu_result[ADDR_W-1:0]; upper bits are ignored (addresses wrap).
- Memory write:
  - Occurs at an edge when mem_valid && mem_MEM_Write && !stall && !reset.
  - Writes mem_store_data.
  - A store is committed exactly once, even if held by stall for several cycles.
- Memory read: combinational from the array at the MEM address. A load directly following a store to the same address returns the newly stored value, because the store commits on the edge the load enters MEM.
- WB register, at each edge with stall=0:
  - write_back = mem_MEM_to_REG ? mem_rdata : mem_alu_result.
  - wb_reg = mem_dest_reg.
  - wb_en = mem_valid && mem_REG_Write.
- WB register, at each edge with stall=1: wb_en=0 (bubble); write_back and wb_reg hold.
- wb_en reflects REG_Write only. A result value of 0 is written like any other value.
- Latency: an instruction presented at edge k appears on write_back/wb_en after edge k+1 (2-stage, 1 cycle registered output), absent stalls.
- retired increments by 1 at each edge where the WB register loads mem_valid=1 (stall=0). Wraps from 2**CNT_W-1 to 0.
- Bubbles:
  - in_valid=0 carries NOP semantics: no memory write, wb_en=0, no retire.
  - A NOP opcode (all controls 0, in_valid=1) retires with wb_en=0.
- MEM_Read with MEM_to_REG=0 is legal: the read is ignored and the ALU result is written back.
- Simultaneous stall and reset: reset wins.

Test Plan:
- Reset: hold reset 2 cycles after random traffic -> wb_en=0, write_back=0, retired=0; subsequent LDM from address 0x05 returns 0x0000.
- ADD passthrough: in_valid=1, alu_result=0x1234, dest_reg=3, REG_Write=1, others 0 at edge k -> after edge k+1: write_back=0x1234, wb_reg=3, wb_en=1; retired=1.
- STD then LDM, back-to-back:
  - STD: alu_result=0x0105, store_data=0xBEEF.
  - LDM: alu_result=0x0005, dest_reg=6, MEM_Read=1, MEM_to_REG=1, REG_Write=1.
  - Required: the STD cycle shows wb_en=0; the LDM gives write_back=0xBEEF, wb_reg=6, wb_en=1 (address wrap plus same-cycle forwarding).
- Stall during store: STD to 0x10 of 0x00AA, stall=1 for 3 cycles, then store_data input changed to 0x00BB:
  - wb_en=0 for the 3 cycles.
  - Single commit after release; memory[0x10]=0x00AA.
  - retired increments once.
- Zero-value write: ADD result 0x0000 to dest_reg=2 -> wb_en=1, write_back=0x0000.
- Counter wrap: force 65536 NOP retirements (CNT_W=16) -> retired returns to 0; wb_en stays 0 throughout.
